// File: rtl/dmem_port_if.sv
// Word-wide data bus between the data-memory port (master) and memory (slave).
// Handshake: a request transfers on a cycle where bus_req_valid and
// bus_req_ready are both high; the master keeps every bus_req_* field stable
// while valid is high and ready is low. A response is a single cycle with
// bus_resp_valid high; bus_resp_err and bus_resp_rdata are meaningful only then,
// and it never arrives in the same cycle as the request handshake.
interface dmem_port_if;
    logic        bus_req_valid;
    logic        bus_req_ready;
    logic        bus_req_we;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_resp_valid;
    logic [31:0] bus_resp_rdata;
    logic        bus_resp_err;

    modport master (
        output bus_req_valid, bus_req_we, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        input  bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_we, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        output bus_req_ready, bus_resp_valid, bus_resp_rdata, bus_resp_err
    );
endinterface

// File: rtl/dmem_port.sv
// Data-memory port: turns a MEM-stage load/store into one valid/ready
// transaction on a word-wide bus, steers byte lanes and extends load data.
package dmem_pkg;
    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BYTE   = 3'd1,
        RD_HALF   = 3'd2,
        RD_WORD   = 3'd3,
        RD_BYTE_U = 3'd4,
        RD_HALF_U = 3'd5
    } mem_read_t;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_BYTE = 2'd1,
        WR_HALF = 2'd2,
        WR_WORD = 2'd3
    } mem_write_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dmem_state_t;
endpackage

module dmem_port
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  mem_read_t    mem_read,
    input  mem_write_t   mem_write,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_stall,
    output logic         mem_misaligned,
    output logic         mem_fault,
    dmem_port_if.master  bus,
    output dmem_state_t  state_dbg
);

    dmem_state_t state, state_next;

    logic        is_write, is_read, access, misal, launch, timeout_hit;
    logic [1:0]  off;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] sh, load_fmt;
    logic [31:0] tmo_cnt;
    mem_read_t   ld_kind;
    logic [1:0]  ld_off;

    assign off       = mem_addr[1:0];
    assign is_write  = (mem_write != WR_NONE);
    assign is_read   = (mem_read != RD_NONE);
    assign access    = is_write | is_read;
    assign state_dbg = state;

    // Alignment check follows the winning access kind (write beats read).
    always_comb begin
        misal = 1'b0;
        if (is_write) begin
            misal = ((mem_write == WR_HALF) && off[0]) ||
                    ((mem_write == WR_WORD) && (off != 2'b00));
        end else begin
            misal = (((mem_read == RD_HALF) || (mem_read == RD_HALF_U)) && off[0]) ||
                    ((mem_read == RD_WORD) && (off != 2'b00));
        end
    end

    assign launch         = (state == ST_IDLE) && access && !misal;
    assign mem_misaligned = (state == ST_IDLE) && access && misal;
    assign mem_stall      = launch || (state == ST_REQ) || (state == ST_WAIT);
    assign timeout_hit    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Store lane steering: strobes shifted by the byte offset, data replicated.
    always_comb begin
        req_wstrb = 4'b0000;
        req_wdata = mem_wdata;
        if (is_write) begin
            case (mem_write)
                WR_BYTE: begin
                    req_wstrb = 4'b0001 << off;
                    req_wdata = {4{mem_wdata[7:0]}};
                end
                WR_HALF: begin
                    req_wstrb = 4'b0011 << off;
                    req_wdata = {2{mem_wdata[15:0]}};
                end
                WR_WORD: req_wstrb = 4'b1111;
                default: req_wstrb = 4'b0000;
            endcase
        end
    end

    // Load extraction from the response word using the captured kind/offset.
    always_comb begin
        sh       = bus.bus_resp_rdata >> {ld_off, 3'b000};
        load_fmt = bus.bus_resp_rdata;
        case (ld_kind)
            RD_BYTE:   load_fmt = {{24{sh[7]}}, sh[7:0]};
            RD_BYTE_U: load_fmt = {24'h0, sh[7:0]};
            RD_HALF:   load_fmt = {{16{sh[15]}}, sh[15:0]};
            RD_HALF_U: load_fmt = {16'h0, sh[15:0]};
            default:   load_fmt = bus.bus_resp_rdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic; DONE always returns to IDLE without relaunching.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (launch) state_next = ST_REQ;
            ST_REQ:  if (bus.bus_req_ready) state_next = ST_WAIT;
            ST_WAIT: if (bus.bus_resp_valid || timeout_hit) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Request capture, timeout counting, and result/fault registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req_valid <= 1'b0;
            bus.bus_req_we    <= 1'b0;
            bus.bus_req_addr  <= 32'h0;
            bus.bus_req_wstrb <= 4'h0;
            bus.bus_req_wdata <= 32'h0;
            ld_kind           <= RD_NONE;
            ld_off            <= 2'b00;
            tmo_cnt           <= 32'h0;
            mem_rdata         <= 32'h0;
            mem_fault         <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= 32'h0;
                    if (launch) begin
                        bus.bus_req_valid <= 1'b1;
                        bus.bus_req_we    <= is_write;
                        bus.bus_req_addr  <= {mem_addr[31:2], 2'b00};
                        bus.bus_req_wstrb <= req_wstrb;
                        bus.bus_req_wdata <= req_wdata;
                        ld_kind           <= is_write ? RD_NONE : mem_read;
                        ld_off            <= off;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_req_ready) bus.bus_req_valid <= 1'b0;
                end
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 32'h1;
                    if (bus.bus_resp_valid) begin
                        if (!bus.bus_req_we) mem_rdata <= load_fmt;
                        mem_fault <= bus.bus_resp_err;
                    end else if (timeout_hit) begin
                        mem_rdata <= 32'h0;
                        mem_fault <= 1'b1;
                    end
                end
                default: tmo_cnt <= 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// Directed bench for dmem_port: one bus responder driven per access, with
// hand-computed expected results.
module tb_dmem_port;
    import dmem_pkg::*;

    logic        clk;
    logic        rst_n;
    mem_read_t   mem_read;
    mem_write_t  mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        mem_fault;
    dmem_state_t state_dbg;

    dmem_port_if bus ();

    dmem_port #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_stall      (mem_stall),
        .mem_misaligned (mem_misaligned),
        .mem_fault      (mem_fault),
        .bus            (bus),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // per-access observations
    int  r_stall, r_fault, r_wait, r_unstable;
    bit  r_done, cap_seen;
    logic        cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // scoreboard: pop the next expected load result and compare
    task automatic sb_check_rdata(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_q_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, mem_rdata, e);
        end
    endtask

    task automatic clear_bus_inputs();
        bus.bus_req_ready  = 1'b0;
        bus.bus_resp_valid = 1'b0;
        bus.bus_resp_err   = 1'b0;
        bus.bus_resp_rdata = 32'h0;
    endtask

    // driver: present one request, play the bus slave, return in the DONE cycle
    task automatic run_access(input mem_read_t rd, input mem_write_t wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ready_dly, input bit respond,
                              input logic [31:0] rdata, input bit err);
        int rdy_cnt;
        bit handshook, resp_given;
        rdy_cnt = 0; handshook = 0; resp_given = 0;
        r_stall = 0; r_fault = 0; r_wait = 0; r_unstable = 0; r_done = 0; cap_seen = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            clear_bus_inputs();
            if (mem_fault) r_fault++;
            if (state_dbg == ST_WAIT) r_wait++;
            if (!mem_stall && r_stall > 0) begin
                r_done = 1;
                break;
            end
            if (mem_stall) r_stall++;
            if (bus.bus_req_valid) begin
                if (!cap_seen) begin
                    cap_we = bus.bus_req_we; cap_addr = bus.bus_req_addr;
                    cap_wstrb = bus.bus_req_wstrb; cap_wdata = bus.bus_req_wdata;
                    cap_seen = 1;
                end else if (bus.bus_req_we != cap_we || bus.bus_req_addr != cap_addr ||
                             bus.bus_req_wstrb != cap_wstrb || bus.bus_req_wdata != cap_wdata) begin
                    r_unstable++;
                end
                if (rdy_cnt >= ready_dly) begin
                    bus.bus_req_ready = 1'b1;
                    handshook = 1;
                end
                rdy_cnt++;
            end else if (handshook && respond && !resp_given) begin
                bus.bus_resp_valid = 1'b1;
                bus.bus_resp_rdata = rdata;
                bus.bus_resp_err   = err;
                resp_given = 1;
            end
            @(negedge clk);
        end
        check("access_completed", 32'(r_done), 32'd1);
        // pipeline advances during DONE
        mem_read = RD_NONE; mem_write = WR_NONE;
    endtask

    // driver: misaligned request must not touch the bus or stall
    task automatic run_misaligned(input string tag, input mem_read_t rd, input mem_write_t wr,
                                  input logic [31:0] addr, input logic [31:0] exp_rdata);
        int v;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = 32'h1234_5678;
        #1;
        check({tag, "_flag"}, 32'(mem_misaligned), 32'd1);
        check({tag, "_stall"}, 32'(mem_stall), 32'd0);
        v = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (bus.bus_req_valid || mem_stall) v++;
        end
        check({tag, "_no_req"}, 32'(v), 32'd0);
        check({tag, "_rdata_kept"}, mem_rdata, exp_rdata);
        mem_read = RD_NONE; mem_write = WR_NONE;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf;
        rst_n = 1'b0;
        mem_read = RD_NONE; mem_write = WR_NONE; mem_addr = 32'h0; mem_wdata = 32'h0;
        clear_bus_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_valid", 32'(bus.bus_req_valid), 32'd0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_fault", 32'(mem_fault), 32'd0);
        check("rst_stall", 32'(mem_stall), 32'd0);
        check("rst_wstrb", 32'(bus.bus_req_wstrb), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // LB 0x1003 -> byte 0x80 sign-extended, 3 stall cycles
        exp_q.push_back(32'hFFFF_FF80);
        run_access(RD_BYTE, WR_NONE, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_1234, 0);
        check("lb_addr", cap_addr, 32'h0000_1000);
        check("lb_wstrb", 32'(cap_wstrb), 32'd0);
        check("lb_we", 32'(cap_we), 32'd0);
        check("lb_stall_cycles", 32'(r_stall), 32'd3);
        check("lb_state_done", 32'(state_dbg), 32'(ST_DONE));
        check("lb_fault", 32'(r_fault), 32'd0);
        sb_check_rdata("lb_rdata");

        exp_q.push_back(32'h0000_0080);
        run_access(RD_BYTE_U, WR_NONE, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_1234, 0);
        sb_check_rdata("lbu_rdata");

        exp_q.push_back(32'h0000_8001);
        run_access(RD_HALF_U, WR_NONE, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_0000, 0);
        sb_check_rdata("lhu_rdata");

        exp_q.push_back(32'hFFFF_8001);
        run_access(RD_HALF, WR_NONE, 32'h0000_2002, 32'h0, 0, 1, 32'h8001_0000, 0);
        sb_check_rdata("lh_rdata");

        exp_q.push_back(32'h80FF_1234);
        run_access(RD_WORD, WR_NONE, 32'h0000_1000, 32'h0, 0, 1, 32'h80FF_1234, 0);
        sb_check_rdata("lw_rdata");

        // stores leave mem_rdata untouched
        run_access(RD_NONE, WR_BYTE, 32'h0000_3001, 32'hAABB_CCDD, 0, 1, 32'hDEAD_BEEF, 0);
        check("sb_we", 32'(cap_we), 32'd1);
        check("sb_wstrb", 32'(cap_wstrb), 32'b0010);
        check("sb_wdata", cap_wdata, 32'hDDDD_DDDD);
        check("sb_addr", cap_addr, 32'h0000_3000);
        check("sb_rdata_kept", mem_rdata, 32'h80FF_1234);

        run_access(RD_NONE, WR_HALF, 32'h0000_3002, 32'hAABB_CCDD, 0, 1, 32'hDEAD_BEEF, 0);
        check("sh_wstrb", 32'(cap_wstrb), 32'b1100);
        check("sh_wdata", cap_wdata, 32'hCCDD_CCDD);
        check("sh_rdata_kept", mem_rdata, 32'h80FF_1234);

        // read and write together: write wins, WORD read offset ignored
        run_access(RD_WORD, WR_BYTE, 32'h0000_3003, 32'h0000_0042, 0, 1, 32'hDEAD_BEEF, 0);
        check("rw_we", 32'(cap_we), 32'd1);
        check("rw_wstrb", 32'(cap_wstrb), 32'b1000);
        check("rw_wdata", cap_wdata, 32'h4242_4242);
        check("rw_rdata_kept", mem_rdata, 32'h80FF_1234);

        run_misaligned("lw_mis", RD_WORD, WR_NONE, 32'h0000_4002, 32'h80FF_1234);
        run_misaligned("sh_mis", RD_NONE, WR_HALF, 32'h0000_4001, 32'h80FF_1234);

        // ready low 5 cycles, then error response
        run_access(RD_WORD, WR_NONE, 32'h0000_5000, 32'h0, 5, 1, 32'h1234_5678, 1);
        check("err_unstable", 32'(r_unstable), 32'd0);
        check("err_stall_cycles", 32'(r_stall), 32'd8);
        check("err_fault_pulses", 32'(r_fault), 32'd1);
        check("err_rdata", mem_rdata, 32'h1234_5678);
        @(negedge clk); #1;
        check("err_fault_cleared", 32'(mem_fault), 32'd0);

        // no response: timeout after 4 WAIT cycles
        run_access(RD_WORD, WR_NONE, 32'h0000_4000, 32'h0, 0, 0, 32'h0, 0);
        check("tmo_wait_cycles", 32'(r_wait), 32'd4);
        check("tmo_stall_cycles", 32'(r_stall), 32'd6);
        check("tmo_fault_pulses", 32'(r_fault), 32'd1);
        check("tmo_rdata", mem_rdata, 32'h0);

        // reset asserted while waiting for the response
        exp_q.push_back(32'h8765_4321);
        run_access(RD_WORD, WR_NONE, 32'h0000_6000, 32'h0, 0, 1, 32'h8765_4321, 0);
        sb_check_rdata("pre_rst_lw");
        @(negedge clk);
        mem_read = RD_WORD; mem_addr = 32'h0000_7000;
        @(negedge clk); #1;
        bus.bus_req_ready = 1'b1;
        @(negedge clk); #1;
        bus.bus_req_ready = 1'b0;
        check("wr_state_wait", 32'(state_dbg), 32'(ST_WAIT));
        rst_n = 1'b0;
        mem_read = RD_NONE;
        #1;
        check("wr_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("wr_valid", 32'(bus.bus_req_valid), 32'd0);
        check("wr_stall", 32'(mem_stall), 32'd0);
        check("wr_rdata", mem_rdata, 32'h0);
        nf = 0;
        repeat (3) begin
            @(negedge clk); #1;
            if (mem_fault) nf++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            if (mem_fault || mem_stall) nf++;
        end
        check("wr_no_fault", 32'(nf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_port.md
Name: dmem_port

Overview:
- Responder end of the MEM-stage data access interface.
- Accepts the load/store request driven by the pipeline's decoded `mem_read_t`/`mem_write_t` controls, plus the ALU-computed address and store data.
- Runs one valid/ready transaction on the external word-wide data bus, aligns byte lanes, and sign/zero-extends load data.
- Holds the pipeline with `mem_stall` until the access completes; flags misaligned accesses and bus faults.

Parameters:
- TIMEOUT_CYCLES, 255, cycles in WAIT before a missing response is declared a fault (0 disables the timeout).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  mem_read_t  load kind (NONE/BYTE/HALF/WORD/BYTE_U/HALF_U)
- mem_write  in  mem_write_t  store kind (NONE/BYTE/HALF/WORD)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, right-aligned
- mem_rdata  out  32  extended load result
- mem_stall  out  1  hold all upstream pipeline registers
- mem_misaligned  out  1  current request is misaligned; no bus access is made
- mem_fault  out  1  one-cycle pulse when the access ends in error or timeout
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_we  out  1  1 = write
- bus_req_addr  out  32  word address, {mem_addr[31:2], 2'b00}
- bus_req_wstrb  out  4  byte enables
- bus_req_wdata  out  32  lane-replicated store data
- bus_resp_valid  in  1  response valid
- bus_resp_rdata  in  32  response word
- bus_resp_err  in  1  response error, qualified by bus_resp_valid

Behaviour:
- Reset: FSM=IDLE, timeout counter=0. All registered outputs are 0: bus_req_*, mem_rdata, mem_fault. Asserting rst_n low mid-transaction aborts it immediately with no pulse. Bus-side cleanup is the bus owner's job.
- access = (mem_write != NONE) | (mem_read != NONE). If both are non-NONE, the write wins and the read is ignored.
- Misaligned: HALF/HALF_U with addr[0]=1, or WORD with addr[1:0]!=0. mem_misaligned is combinational and asserted only in IDLE. No stall, no transaction, and mem_rdata keeps its previous value.
- FSM IDLE: on an aligned access, register we/addr/wstrb/wdata, the load kind, and addr[1:0], then go to REQ. mem_stall=1 combinationally in this cycle.
- FSM REQ: bus_req_valid=1 with stable fields until bus_req_ready=1, then go to WAIT. A response is never expected in the handshake cycle.
- FSM WAIT: the counter increments each cycle.
  - On bus_resp_valid, register the formatted rdata (writes leave mem_rdata unchanged) and go to DONE; mem_fault is set for DONE when err=1.
  - On counter = TIMEOUT_CYCLES-1 with no response, set mem_rdata=0 and mem_fault for DONE, then go to DONE.
- FSM DONE: mem_stall=0, mem_rdata is valid, mem_fault pulses if set. The next state is always IDLE. The still-present request inputs are not relaunched.
- mem_stall = (IDLE & access & aligned) | REQ | WAIT.
- Store lanes by offset `o` = addr[1:0]:
  - BYTE: wstrb=4'b0001<<o, wdata={4{wdata[7:0]}}
  - HALF: wstrb=4'b0011<<o, wdata={2{wdata[15:0]}}
  - WORD: wstrb=4'b1111, wdata as given
  - All loads: wstrb=0
- Load extraction: sh = rdata >> (8*o). BYTE sign-extends sh[7:0], BYTE_U zero-extends it; HALF sign-extends sh[15:0], HALF_U zero-extends it; WORD passes rdata through.
- Minimum load latency: IDLE→REQ→WAIT→DONE = 3 stall cycles when ready and resp each arrive on the first possible cycle.

Test Plan:
- LB at 0x1003, bus returns 0x80FF_1234 with immediate ready and next-cycle resp → bus_req_addr=0x1000, wstrb=0, mem_rdata=0xFFFF_FF80, stall high exactly 3 cycles, then DONE.
- LHU at 0x2002, resp 0x8001_0000 → mem_rdata=0x0000_8001. LH at the same address → mem_rdata=0xFFFF_8001.
- SB at 0x3001 with mem_wdata=0xAABB_CCDD → wstrb=4'b0010, bus_req_wdata=0xDDDD_DDDD, we=1. SH at 0x3002 → wstrb=4'b1100, wdata=0xCCDD_CCDD.
- bus_req_ready held low 5 cycles, then bus_resp_err=1 → bus_req fields stable throughout, stall spans all cycles, single mem_fault pulse in DONE.
- LW at 0x4002 → mem_misaligned=1 same cycle, stall=0, bus_req_valid never asserts. With TIMEOUT_CYCLES=4 and no response → fault pulse after 4 WAIT cycles, mem_rdata=0.
- rst_n low while in WAIT → next cycle FSM=IDLE, bus_req_valid=0, mem_stall=0, no fault pulse.
